// File: rtl/reglist_sequencer_pkg.sv
// reglist_sequencer_pkg: op codes, FSM states, special register
// indices and default address step shared by the reglist sequencer.
package reglist_sequencer_pkg;

    localparam int unsigned ADDR_STEP_DEF = 4;
    localparam int unsigned LIST_W        = 9;

    localparam logic [3:0] IDX_SP = 4'd13;
    localparam logic [3:0] IDX_LR = 4'd14;
    localparam logic [3:0] IDX_PC = 4'd15;

    typedef enum logic [1:0] {
        OP_STM  = 2'b00,
        OP_LDM  = 2'b01,
        OP_PUSH = 2'b10,
        OP_POP  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_XFER  = 3'd2,
        S_WB    = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    // List bit 8 names LR for PUSH and PC for POP.
    function automatic logic [3:0] list_bit_to_reg(
        input logic [3:0] bit_idx,
        input op_e        op
    );
        logic [3:0] r;
        r = bit_idx;
        if (bit_idx == 4'd8) begin
            r = (op == OP_PUSH) ? IDX_LR : IDX_PC;
        end
        return r;
    endfunction

endpackage

// File: rtl/reglist_scan.sv
// reglist_scan: combinational scan of a 9-bit register list.
// Ports: i_list in; o_low_idx lowest set bit, o_count popcount, o_empty.
module reglist_scan
    import reglist_sequencer_pkg::*;
(
    input  logic [LIST_W-1:0] i_list,
    output logic [3:0]        o_low_idx,
    output logic [3:0]        o_count,
    output logic              o_empty
);

    always_comb begin
        o_low_idx = '0;
        o_count   = '0;
        // Descending walk so the last hit is the lowest set bit.
        for (int i = LIST_W - 1; i >= 0; i--) begin
            if (i_list[i]) begin
                o_low_idx = 4'(i);
            end
        end
        for (int i = 0; i < LIST_W; i++) begin
            o_count = o_count + 4'(i_list[i]);
        end
    end

    assign o_empty = (i_list == '0);

endmodule

// File: rtl/reglist_sequencer.sv
// reglist_sequencer: walks a PUSH/POP/LDM/STM register list lowest-first,
// one req/ack memory access per register, then base/SP writeback.
// Ports: clk, rst (sync, active-high); start/op/reg_list/base_idx/base_val
// launch; rf_raddr/rf_rdata store read; rf_we/rf_waddr/rf_wdata write;
// pc_ld/pc_data PC load; mem_req/we/addr/wdata/ack/rdata memory port;
// busy/done/err status.
// Build option: define REGSEQ_POP_PC_EN to let POP bit 8 load the PC;
// otherwise bit 8 is dropped for POP and pc_ld stays low.
module reglist_sequencer
    import reglist_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_STEP = ADDR_STEP_DEF,
    parameter int unsigned AW        = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [8:0]    reg_list,
    input  logic [2:0]    base_idx,
    input  logic [31:0]   base_val,
    output logic [3:0]    rf_raddr,
    input  logic [31:0]   rf_rdata,
    output logic          rf_we,
    output logic [3:0]    rf_waddr,
    output logic [31:0]   rf_wdata,
    output logic          pc_ld,
    output logic [31:0]   pc_data,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic          mem_ack,
    input  logic [31:0]   mem_rdata,
    output logic          busy,
    output logic          done,
    output logic          err
);

    state_e              r_state;
    state_e              w_next;
    op_e                 r_op;
    op_e                 w_op;
    logic [LIST_W-1:0]   r_list;
    logic [LIST_W-1:0]   w_eff;
    logic [LIST_W-1:0]   w_low_mask;
    logic [2:0]          r_base_idx;
    logic                r_wb_en;
    logic [AW-1:0]       r_addr;
    logic [AW-1:0]       r_start;
    logic [AW-1:0]       w_offset;
    logic [AW-1:0]       w_start_addr;
    logic [3:0]          r_n;
    logic [3:0]          w_low_idx;
    logic [3:0]          w_count;
    logic                w_empty;
    logic [3:0]          w_cur_reg;
    logic                w_is_load;
    logic                r_rf_we;
    logic [3:0]          r_rf_waddr;
    logic [31:0]         r_rf_wdata;

    reglist_scan u_scan (
        .i_list    (r_list),
        .o_low_idx (w_low_idx),
        .o_count   (w_count),
        .o_empty   (w_empty)
    );

    assign w_op       = op_e'(op);
    assign w_is_load  = (r_op == OP_LDM) || (r_op == OP_POP);
    assign w_cur_reg  = list_bit_to_reg(w_low_idx, r_op);
    assign w_low_mask = LIST_W'(1) << w_low_idx;
    assign w_offset   = AW'(w_count) * AW'(ADDR_STEP);
    assign w_start_addr = (r_op == OP_PUSH) ? r_addr - w_offset : r_addr;

    // Bit 8 only has meaning for PUSH (LR) and, when enabled, POP (PC).
    always_comb begin
        w_eff = reg_list;
        if ((w_op == OP_LDM) || (w_op == OP_STM)) begin
            w_eff[8] = 1'b0;
        end
`ifndef REGSEQ_POP_PC_EN
        if (w_op == OP_POP) begin
            w_eff[8] = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        busy      = (r_state != S_IDLE);
        done      = 1'b0;
        err       = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        rf_raddr  = '0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_SETUP;
                end
            end
            S_SETUP: begin
                w_next = w_empty ? S_DONE : S_XFER;
            end
            S_XFER: begin
                mem_req  = 1'b1;
                mem_we   = !w_is_load;
                mem_addr = r_addr;
                if (!w_is_load) begin
                    rf_raddr  = w_cur_reg;
                    mem_wdata = rf_rdata;
                end
                if (mem_ack && (w_count == 4'd1)) begin
                    w_next = S_WB;
                end
            end
            S_WB: begin
                w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                err    = (r_n == 4'd0);
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

`ifdef REGSEQ_POP_PC_EN
    logic        r_pc_ld;
    logic [31:0] r_pc_data;
    assign pc_ld   = r_pc_ld;
    assign pc_data = r_pc_data;
`else
    assign pc_ld   = 1'b0;
    assign pc_data = '0;
`endif

    // Register-file writes are registered: a load lands the cycle
    // after its ack edge, the base/SP writeback lands in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op       <= OP_STM;
            r_list     <= '0;
            r_base_idx <= '0;
            r_wb_en    <= 1'b0;
            r_addr     <= '0;
            r_start    <= '0;
            r_n        <= '0;
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
`ifdef REGSEQ_POP_PC_EN
            r_pc_ld    <= 1'b0;
            r_pc_data  <= '0;
`endif
        end else begin
            r_rf_we <= 1'b0;
`ifdef REGSEQ_POP_PC_EN
            r_pc_ld <= 1'b0;
`endif
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op       <= w_op;
                        r_list     <= w_eff;
                        r_base_idx <= base_idx;
                        // LDM with Rn in the list keeps the loaded value.
                        r_wb_en    <= !((w_op == OP_LDM) && reg_list[base_idx]);
                        r_addr     <= AW'(base_val);
                    end
                end
                S_SETUP: begin
                    r_n     <= w_count;
                    r_addr  <= w_start_addr;
                    r_start <= w_start_addr;
                end
                S_XFER: begin
                    if (mem_ack) begin
                        r_list <= r_list & ~w_low_mask;
                        r_addr <= r_addr + AW'(ADDR_STEP);
                        if (w_is_load) begin
`ifdef REGSEQ_POP_PC_EN
                            if (w_cur_reg == IDX_PC) begin
                                r_pc_ld   <= 1'b1;
                                r_pc_data <= mem_rdata;
                            end else begin
                                r_rf_we    <= 1'b1;
                                r_rf_waddr <= w_cur_reg;
                                r_rf_wdata <= mem_rdata;
                            end
`else
                            r_rf_we    <= 1'b1;
                            r_rf_waddr <= w_cur_reg;
                            r_rf_wdata <= mem_rdata;
`endif
                        end
                    end
                end
                S_WB: begin
                    if (r_wb_en) begin
                        r_rf_we <= 1'b1;
                        if ((r_op == OP_PUSH) || (r_op == OP_POP)) begin
                            r_rf_waddr <= IDX_SP;
                        end else begin
                            r_rf_waddr <= {1'b0, r_base_idx};
                        end
                        // After the walk r_addr = start + N*step.
                        r_rf_wdata <= 32'((r_op == OP_PUSH) ? r_start : r_addr);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rf_we    = r_rf_we;
    assign rf_waddr = r_rf_waddr;
    assign rf_wdata = r_rf_wdata;

endmodule

// File: tb/tb_reglist_sequencer.sv
// tb_reglist_sequencer: directed vector table, reset-abort sequence and
// randomized operations checked against a list-walking reference model.
module tb_reglist_sequencer;

    localparam logic [1:0] STM  = 2'b00;
    localparam logic [1:0] LDM  = 2'b01;
    localparam logic [1:0] PUSH = 2'b10;
    localparam logic [1:0] POP  = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [8:0]  reg_list;
    logic [2:0]  base_idx;
    logic [31:0] base_val;
    logic [3:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        pc_ld;
    logic [31:0] pc_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    reglist_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .reg_list  (reg_list),
        .base_idx  (base_idx),
        .base_val  (base_val),
        .rf_raddr  (rf_raddr),
        .rf_rdata  (rf_rdata),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .pc_ld     (pc_ld),
        .pc_data   (pc_data),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    logic [31:0] rf_m [16];
    logic [31:0] mem_m [logic [31:0]];
    assign rf_rdata = rf_m[rf_raddr];

    int checks   = 0;
    int failures = 0;

    logic [3:0]  got_rf_a [$];
    logic [31:0] got_rf_d [$];
    logic [31:0] got_pc   [$];
    logic [31:0] got_ma   [$];
    logic [31:0] got_md   [$];
    logic        got_mwe  [$];
    int          got_done;
    logic        got_err;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [8:0] l,
                          input logic [2:0] bi, input logic [31:0] bv,
                          input int w, input bit noise);
        logic [8:0]  eff;
        logic [31:0] rf0 [16];
        logic [31:0] sa, a, d, ta, td;
        logic [3:0]  r;
        logic        twe, in_txn, done_seen, post_ok, store;
        logic [3:0]  e_rf_a [$];
        logic [31:0] e_rf_d [$];
        logic [31:0] e_pc   [$];
        logic [31:0] e_ma   [$];
        logic [31:0] e_md   [$];
        logic        e_mwe  [$];
        int n, k, cyc, wcnt, e_done, limit, unstable, busy_bad;

        // Reference: walk the effective list from the ISA rules.
        store = (o == PUSH) || (o == STM);
        eff = l;
        if (o == LDM || o == STM) eff[8] = 1'b0;
`ifndef REGSEQ_POP_PC_EN
        if (o == POP) eff[8] = 1'b0;
`endif
        n = 0;
        for (int i = 0; i < 9; i++) if (eff[i]) n++;
        sa = (o == PUSH) ? bv - 32'(4 * n) : bv;
        rf0 = rf_m;
        k = 0;
        for (int i = 0; i < 9; i++) begin
            if (eff[i]) begin
                a = sa + 32'(4 * k);
                k++;
                r = (i < 8) ? 4'(i) : ((o == PUSH) ? 4'd14 : 4'd15);
                e_ma.push_back(a);
                e_mwe.push_back(store);
                if (store) begin
                    e_md.push_back(rf0[r]);
                end else begin
                    if (!mem_m.exists(a)) mem_m[a] = $urandom;
                    d = mem_m[a];
                    e_md.push_back(d);
                    if (r == 4'd15) e_pc.push_back(d);
                    else begin
                        e_rf_a.push_back(r);
                        e_rf_d.push_back(d);
                    end
                end
            end
        end
        if (n > 0) begin
            case (o)
                PUSH: begin e_rf_a.push_back(4'd13); e_rf_d.push_back(sa); end
                POP: begin
                    e_rf_a.push_back(4'd13);
                    e_rf_d.push_back(bv + 32'(4 * n));
                end
                STM: begin
                    e_rf_a.push_back({1'b0, bi});
                    e_rf_d.push_back(bv + 32'(4 * n));
                end
                default: begin
                    if (!l[bi]) begin
                        e_rf_a.push_back({1'b0, bi});
                        e_rf_d.push_back(bv + 32'(4 * n));
                    end
                end
            endcase
        end
        e_done = (n == 0) ? 2 : n + 3 + n * w;

        got_rf_a.delete(); got_rf_d.delete(); got_pc.delete();
        got_ma.delete(); got_md.delete(); got_mwe.delete();
        got_done = -1;
        got_err  = 1'b0;

        @(negedge clk);
        start = 1'b1; op = o; reg_list = l; base_idx = bi; base_val = bv;
        mem_ack = 1'b0;
        cyc = 0; wcnt = 0; in_txn = 1'b0; done_seen = 1'b0;
        unstable = 0; busy_bad = 0; post_ok = 1'b0;
        ta = '0; td = '0; twe = 1'b0;
        limit = e_done + 30;
        while (cyc < limit) begin
            @(negedge clk);
            cyc++;
            if (done_seen) begin
                post_ok = !busy && !mem_req && !rf_we && !done && !pc_ld;
                mem_ack = 1'b0;
                break;
            end
            if (rf_we) begin
                got_rf_a.push_back(rf_waddr);
                got_rf_d.push_back(rf_wdata);
                rf_m[rf_waddr] = rf_wdata;
            end
            if (pc_ld) got_pc.push_back(pc_data);
            if (busy !== 1'b1) busy_bad++;
            if (done) begin
                done_seen = 1'b1;
                got_done  = cyc;
                got_err   = err;
            end
            if (mem_req === 1'b1) begin
                if (!in_txn) begin
                    in_txn = 1'b1; wcnt = 0;
                    ta = mem_addr; twe = mem_we; td = mem_wdata;
                end else if (mem_addr !== ta || mem_we !== twe || mem_wdata !== td) begin
                    unstable++;
                end
                if (wcnt >= w) begin
                    mem_ack = 1'b1;
                    if (twe) begin
                        mem_m[ta] = td;
                        d = td;
                    end else begin
                        d = mem_m.exists(ta) ? mem_m[ta] : (32'hDEAD0000 ^ ta);
                        mem_rdata = d;
                    end
                    got_ma.push_back(ta);
                    got_mwe.push_back(twe);
                    got_md.push_back(d);
                    in_txn = 1'b0;
                end else begin
                    mem_ack = 1'b0;
                    wcnt++;
                    mem_rdata = $urandom;
                end
            end else begin
                mem_ack   = noise ? 1'($urandom) : 1'b0;
                mem_rdata = $urandom;
            end
            if (done_seen || !noise) begin
                start = 1'b0;
            end else begin
                start    = 1'($urandom);
                op       = 2'($urandom);
                reg_list = 9'($urandom);
                base_idx = 3'($urandom);
                base_val = $urandom;
            end
        end

        chk("done_seen", 32'(done_seen), 32'd1);
        chk("done_cycle", 32'(got_done), 32'(e_done));
        chk("err", 32'(got_err), 32'(n == 0));
        chk("busy_while_active", 32'(busy_bad), 32'd0);
        chk("idle_after_done", 32'(post_ok), 32'd1);
        chk("mem_stable", 32'(unstable), 32'd0);
        chk("mem_count", 32'(got_ma.size()), 32'(e_ma.size()));
        for (int i = 0; i < e_ma.size() && i < got_ma.size(); i++) begin
            chk($sformatf("mem%0d_addr", i), got_ma[i], e_ma[i]);
            chk($sformatf("mem%0d_we", i), 32'(got_mwe[i]), 32'(e_mwe[i]));
            chk($sformatf("mem%0d_data", i), got_md[i], e_md[i]);
        end
        chk("rf_write_count", 32'(got_rf_a.size()), 32'(e_rf_a.size()));
        for (int i = 0; i < e_rf_a.size() && i < got_rf_a.size(); i++) begin
            chk($sformatf("rfw%0d_addr", i), 32'(got_rf_a[i]), 32'(e_rf_a[i]));
            chk($sformatf("rfw%0d_data", i), got_rf_d[i], e_rf_d[i]);
        end
        chk("pc_load_count", 32'(got_pc.size()), 32'(e_pc.size()));
        for (int i = 0; i < e_pc.size() && i < got_pc.size(); i++) begin
            chk($sformatf("pc%0d_data", i), got_pc[i], e_pc[i]);
        end
    endtask

    typedef struct {
        logic [1:0]  v_op;
        logic [8:0]  v_list;
        logic [2:0]  v_bidx;
        logic [31:0] v_base;
        int          v_waits;
        int          x_done;
        logic        x_err;
        int          x_nmem;
        logic [31:0] x_first;
        int          x_nrfw;
        logic [3:0]  x_last_a;
        logic [31:0] x_last_d;
    } vec_t;

    vec_t vec [8];

    initial begin
        int bad;
        logic [1:0]  o;
        logic [8:0]  l;
        logic [31:0] bv;

        rst = 1'b1; start = 1'b0; op = '0; reg_list = '0; base_idx = '0;
        base_val = '0; mem_ack = 1'b0; mem_rdata = '0;
        for (int i = 0; i < 16; i++) rf_m[i] = 32'hC0DE0000 | 32'(i * 32'h0101);

        repeat (3) @(negedge clk);
        chk("reset_status", {26'd0, busy, done, err, mem_req, rf_we, pc_ld}, 32'd0);
        chk("reset_mem_addr", mem_addr, 32'd0);
        chk("reset_mem_wdata", mem_wdata, 32'd0);
        chk("reset_rf_wdata", rf_wdata, 32'd0);
        chk("reset_pc_data", pc_data, 32'd0);
        chk("reset_rf_idx", {24'd0, rf_raddr, rf_waddr}, 32'd0);
        rst = 1'b0;

`ifdef REGSEQ_POP_PC_EN
        vec[0] = '{POP, 9'h101, 3'd0, 32'hF8, 0, 5, 1'b0, 2, 32'hF8, 2, 4'd13, 32'h100};
`else
        vec[0] = '{POP, 9'h101, 3'd0, 32'hF8, 0, 4, 1'b0, 1, 32'hF8, 2, 4'd13, 32'hFC};
`endif
        vec[1] = '{LDM, 9'h006, 3'd2, 32'h200, 0, 5, 1'b0, 2, 32'h200, 2, 4'd2, 32'hA4};
        vec[2] = '{STM, 9'h008, 3'd0, 32'h300, 2, 6, 1'b0, 1, 32'h300, 1, 4'd0, 32'h304};
        vec[3] = '{PUSH, 9'h130, 3'd0, 32'h100, 0, 6, 1'b0, 3, 32'hF4, 1, 4'd13, 32'hF4};
        vec[4] = '{PUSH, 9'h000, 3'd0, 32'h500, 0, 2, 1'b1, 0, 32'h0, 0, 4'd0, 32'h0};
        vec[5] = '{LDM, 9'h100, 3'd3, 32'h600, 0, 2, 1'b1, 0, 32'h0, 0, 4'd0, 32'h0};
        vec[6] = '{STM, 9'h0FF, 3'd0, 32'hFFFFFFF8, 0, 11, 1'b0, 8, 32'hFFFFFFF8,
                   1, 4'd0, 32'h18};
        vec[7] = '{PUSH, 9'h1FF, 3'd0, 32'h10, 0, 12, 1'b0, 9, 32'hFFFFFFEC,
                   1, 4'd13, 32'hFFFFFFEC};

        mem_m[32'hF8]  = 32'h11;
        mem_m[32'hFC]  = 32'h40;
        mem_m[32'h200] = 32'hA0;
        mem_m[32'h204] = 32'hA4;

        for (int i = 0; i < 8; i++) begin
            run_op(vec[i].v_op, vec[i].v_list, vec[i].v_bidx, vec[i].v_base,
                   vec[i].v_waits, 1'b0);
            chk($sformatf("vec%0d_done", i), 32'(got_done), 32'(vec[i].x_done));
            chk($sformatf("vec%0d_err", i), 32'(got_err), 32'(vec[i].x_err));
            chk($sformatf("vec%0d_nmem", i), 32'(got_ma.size()), 32'(vec[i].x_nmem));
            if (vec[i].x_nmem > 0 && got_ma.size() > 0)
                chk($sformatf("vec%0d_first_addr", i), got_ma[0], vec[i].x_first);
            chk($sformatf("vec%0d_nrfw", i), 32'(got_rf_a.size()), 32'(vec[i].x_nrfw));
            if (vec[i].x_nrfw > 0 && got_rf_a.size() > 0) begin
                chk($sformatf("vec%0d_last_waddr", i),
                    32'(got_rf_a[got_rf_a.size() - 1]), 32'(vec[i].x_last_a));
                chk($sformatf("vec%0d_last_wdata", i),
                    got_rf_d[got_rf_d.size() - 1], vec[i].x_last_d);
            end
        end

        // Reset in the middle of a 3-register PUSH.
        bad = 0;
        @(negedge clk);
        start = 1'b1; op = PUSH; reg_list = 9'h00E; base_idx = '0;
        base_val = 32'h400; mem_ack = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            mem_ack = mem_req;
            if (rf_we) bad++;
        end
        chk("rst_mid_in_xfer", 32'(mem_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_req", 32'(mem_req), 32'd0);
        rst = 1'b0;
        mem_ack = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rf_we || busy || mem_req || done) bad++;
        end
        chk("rst_mid_no_writeback", 32'(bad), 32'd0);

        for (int t = 0; t < 40; t++) begin
            o = 2'($urandom);
            l = ($urandom % 5 == 0) ? 9'(($urandom % 2) << 8) : 9'($urandom);
            bv = ($urandom % 4 == 0) ? 32'hFFFFFFF0 + ($urandom % 32)
                                     : ($urandom & 32'hFFFFFFFC);
            run_op(o, l, 3'($urandom), bv, int'($urandom % 3), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
